// File: rtl/vx_tensor_hmma_sequencer.sv
// Expands one HMMA macro per warp into the 2*NUM_STEPS micro-op stream for the tensor core
// and holds the core for that warp until every commit beat of the macro has come back.
`ifndef NW_WIDTH
`define NW_WIDTH 4
`endif
`ifndef UUID_WIDTH
`define UUID_WIDTH 32
`endif
`ifndef NR_BITS
`define NR_BITS 5
`endif

module vx_tensor_hmma_sequencer #(
   parameter int NW_WIDTH   = `NW_WIDTH,
   parameter int UUID_WIDTH = `UUID_WIDTH,
   parameter int NR_BITS    = `NR_BITS,
   parameter int NUM_STEPS  = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [NW_WIDTH-1:0]   req_wid,
   input  logic [UUID_WIDTH-1:0] req_uuid,
   input  logic [NR_BITS-1:0]    req_rd,
   output logic                  uop_valid,
   input  logic                  uop_ready,
   output logic [NW_WIDTH-1:0]   uop_wid,
   output logic [UUID_WIDTH-1:0] uop_uuid,
   output logic [1:0]            uop_step,
   output logic                  uop_sub,
   output logic [NR_BITS-1:0]    uop_rd,
   output logic                  uop_last,
   input  logic                  cmt_fire,
   input  logic [NW_WIDTH-1:0]   cmt_wid,
   output logic                  done_valid,
   output logic [NW_WIDTH-1:0]   done_wid,
   output logic                  busy,
   output logic                  err
);

   localparam logic [2:0] ICNT_LAST = 3'(2 * NUM_STEPS - 1);
   localparam logic [3:0] OCNT_MAX  = 4'(2 * NUM_STEPS);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                state_reg, state_next;
   logic [2:0]            icnt_reg, icnt_next;
   logic [3:0]            ocnt_reg, ocnt_next;
   logic                  err_reg, err_next;
   logic [NW_WIDTH-1:0]   wid_reg, wid_next;
   logic [UUID_WIDTH-1:0] uuid_reg, uuid_next;
   logic [NR_BITS-1:0]    rd_reg, rd_next;

   logic req_fire;
   logic uop_fire;
   logic icnt_last;
   logic cmt_ok;
   logic cmt_bad;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         icnt_reg  <= '0;
         ocnt_reg  <= '0;
         err_reg   <= 1'b0;
         wid_reg   <= '0;
         uuid_reg  <= '0;
         rd_reg    <= '0;
      end else begin
         state_reg <= state_next;
         icnt_reg  <= icnt_next;
         ocnt_reg  <= ocnt_next;
         err_reg   <= err_next;
         wid_reg   <= wid_next;
         uuid_reg  <= uuid_next;
         rd_reg    <= rd_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      icnt_next  = icnt_reg;
      ocnt_next  = ocnt_reg;
      err_next   = err_reg;
      wid_next   = wid_reg;
      uuid_next  = uuid_reg;
      rd_next    = rd_reg;

      req_fire  = (state_reg == S_IDLE) && req_valid;
      uop_fire  = (state_reg == S_ISSUE) && uop_ready;
      icnt_last = (icnt_reg == ICNT_LAST);

      // A commit beat only counts if it belongs to the locked warp and has a uop to retire;
      // a uop firing in the same cycle covers the ocnt == 0 case.
      cmt_ok  = cmt_fire && (state_reg != S_IDLE) && (cmt_wid == wid_reg)
                && ((ocnt_reg != 4'd0) || uop_fire);
      cmt_bad = cmt_fire && !cmt_ok;

      if (cmt_bad) begin
         err_next = 1'b1;
      end

      if (uop_fire && !cmt_ok) begin
         if (ocnt_reg == OCNT_MAX) begin
            err_next = 1'b1;
         end else begin
            ocnt_next = ocnt_reg + 4'd1;
         end
      end else if (!uop_fire && cmt_ok) begin
         ocnt_next = ocnt_reg - 4'd1;
      end

      case (state_reg)
         S_IDLE: begin
            if (req_fire) begin
               wid_next   = req_wid;
               uuid_next  = req_uuid;
               rd_next    = req_rd;
               icnt_next  = '0;
               ocnt_next  = '0;
               state_next = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (uop_fire) begin
               icnt_next = icnt_reg + 3'd1;
               if (icnt_last) begin
                  state_next = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if ((ocnt_reg == 4'd0) || ((ocnt_reg == 4'd1) && cmt_ok)) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Every output is a decode of registered state, so neither handshake input reaches an output.
   assign req_ready  = (state_reg == S_IDLE);
   assign uop_valid  = (state_reg == S_ISSUE);
   assign uop_wid    = wid_reg;
   assign uop_uuid   = uuid_reg;
   assign uop_step   = icnt_reg[2:1];
   assign uop_sub    = icnt_reg[0];
   assign uop_rd     = rd_reg + NR_BITS'(icnt_reg[0]);
   assign uop_last   = (state_reg == S_ISSUE) && icnt_last;
   assign done_valid = (state_reg == S_DONE);
   assign done_wid   = wid_reg;
   assign busy       = (state_reg != S_IDLE);
   assign err        = err_reg;

endmodule
